// File: rtl/cache_tag_lookup_ctrl.sv
// Controller for a 2-way set-associative tag store: clear sweep after reset,
// tag compare with per-set LRU, and a miss/refill handshake with tag write-back.
module cache_tag_lookup_ctrl #(
  parameter int unsigned INDEX_WIDTH = 7,
  parameter int unsigned TAG_WIDTH   = 20,
  parameter int unsigned WORD_WIDTH  = 45
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [INDEX_WIDTH-1:0] req_index,
  input  logic [TAG_WIDTH-1:0]   req_tag,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic                   resp_way,
  output logic                   miss_valid,
  input  logic                   miss_ready,
  output logic [INDEX_WIDTH-1:0] miss_index,
  output logic [TAG_WIDTH-1:0]   miss_tag,
  output logic                   miss_way,
  input  logic                   refill_done,
  output logic [INDEX_WIDTH-1:0] tag_raddr,
  output logic                   tag_re,
  output logic [INDEX_WIDTH-1:0] tag_waddr,
  output logic                   tag_we,
  output logic [INDEX_WIDTH-1:0] tag_lru_addr,
  output logic                   tag_refill,
  output logic                   tag_select,
  output logic                   tag_init_n,
  output logic [WORD_WIDTH-1:0]  tag_din,
  input  logic [WORD_WIDTH-1:0]  tag_dout
);

  localparam int unsigned FW      = TAG_WIDTH + 1;
  localparam int unsigned W1_LO   = FW + 1;
  localparam int unsigned LRU_BIT = 2 * FW + 2;

  typedef enum logic [2:0] {
    INIT, IDLE, LOOKUP, MISS, REFILL_WAIT, REFILL_WR
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [INDEX_WIDTH-1:0] r_init_cnt;
  logic [INDEX_WIDTH-1:0] r_index;
  logic [TAG_WIDTH-1:0]   r_tag;
  logic [WORD_WIDTH-1:0]  r_old_word;
  logic                   r_victim;

  logic [FW-1:0]          w_way0;
  logic [FW-1:0]          w_way1;
  logic                   w_hit0;
  logic                   w_hit1;
  logic                   w_hit;
  logic                   w_hit_way;
  logic                   w_victim;
  logic [WORD_WIDTH-1:0]  w_refill_word;

  assign w_way0    = tag_dout[FW-1:0];
  assign w_way1    = tag_dout[W1_LO +: FW];
  assign w_hit0    = w_way0[FW-1] & (w_way0[TAG_WIDTH-1:0] == r_tag);
  assign w_hit1    = w_way1[FW-1] & (w_way1[TAG_WIDTH-1:0] == r_tag);
  assign w_hit     = w_hit0 | w_hit1;
  assign w_hit_way = ~w_hit0;
  // Fill an invalid way first (way 0 preferred); otherwise evict the LRU way.
  assign w_victim  = ~w_way0[FW-1] ? 1'b0 :
                     ~w_way1[FW-1] ? 1'b1 : tag_dout[LRU_BIT];

  assign tag_select = 1'b0;

  always_comb begin
    w_refill_word              = r_old_word;
    w_refill_word[LRU_BIT]     = ~r_victim;
    w_refill_word[LRU_BIT-1]   = 1'b0;
    w_refill_word[FW]          = 1'b0;
    if (r_victim) begin
      w_refill_word[W1_LO +: FW] = {1'b1, r_tag};
    end else begin
      w_refill_word[FW-1:0]      = {1'b1, r_tag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
      r_index    <= '0;
      r_tag      <= '0;
      r_old_word <= '0;
      r_victim   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        INIT: r_init_cnt <= r_init_cnt + 1'b1;
        IDLE: begin
          if (req_valid) begin
            r_index <= req_index;
            r_tag   <= req_tag;
          end
        end
        LOOKUP: begin
          r_old_word <= tag_dout;
          r_victim   <= w_victim;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_hit     = 1'b0;
    resp_way     = 1'b0;
    miss_valid   = 1'b0;
    miss_index   = '0;
    miss_tag     = '0;
    miss_way     = 1'b0;
    tag_raddr    = '0;
    tag_re       = 1'b0;
    tag_waddr    = '0;
    tag_we       = 1'b0;
    tag_lru_addr = '0;
    tag_refill   = 1'b0;
    tag_init_n   = 1'b1;
    tag_din      = '0;
    case (r_state)
      INIT: begin
        tag_init_n = 1'b0;
        if (r_init_cnt == '1) w_next_state = IDLE;
      end
      IDLE: begin
        req_ready = 1'b1;
        tag_raddr = req_index;
        tag_re    = req_valid;
        if (req_valid) w_next_state = LOOKUP;
      end
      LOOKUP: begin
        if (w_hit) begin
          resp_valid       = 1'b1;
          resp_hit         = 1'b1;
          resp_way         = w_hit_way;
          tag_we           = 1'b1;
          tag_lru_addr     = r_index;
          tag_din[LRU_BIT] = ~w_hit_way;
          w_next_state     = IDLE;
        end else begin
          w_next_state = MISS;
        end
      end
      MISS: begin
        miss_valid = 1'b1;
        miss_index = r_index;
        miss_tag   = r_tag;
        miss_way   = r_victim;
        if (miss_ready) w_next_state = REFILL_WAIT;
      end
      REFILL_WAIT: begin
        if (refill_done) w_next_state = REFILL_WR;
      end
      REFILL_WR: begin
        tag_refill   = 1'b1;
        tag_waddr    = r_index;
        tag_din      = w_refill_word;
        resp_valid   = 1'b1;
        resp_way     = r_victim;
        w_next_state = IDLE;
      end
      default: w_next_state = INIT;
    endcase
  end

endmodule

// File: doc/cache_tag_lookup_ctrl.md
Name: cache_tag_lookup_ctrl

Overview:
- Initiator/controller side of the 2-way, 128-set cache tag store (45-bit tag word; the tag RAM is a separate block).
- Clears the tag store after reset, then accepts lookup requests and compares tags to produce hit/miss and the hit way.
- Maintains the per-set LRU bit, chooses the victim, and runs a miss/refill handshake with the line refill engine.
- Writes the refilled tag word back into the tag store.

Parameters:
- INDEX_WIDTH, 7, set index width; the controller handles 1<<INDEX_WIDTH sets.
- TAG_WIDTH, 20, address tag width. Each way entry is {valid, tag}, 21 bits.
- WORD_WIDTH, 45, tag-store word width. Layout: {lru[44], 0[43], way1[42:22], 0[21], way0[20:0]}.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  lookup request
- req_ready  out  1  controller can accept a request
- req_index  in  INDEX_WIDTH  set index
- req_tag  in  TAG_WIDTH  address tag
- resp_valid  out  1  one-cycle response strobe
- resp_hit  out  1  1 = hit, 0 = completed after miss/refill
- resp_way  out  1  way that holds the line
- miss_valid  out  1  refill request to the refill engine
- miss_ready  in  1  refill engine accepts the request
- miss_index  out  INDEX_WIDTH  set being refilled
- miss_tag  out  TAG_WIDTH  tag being refilled
- miss_way  out  1  victim way
- refill_done  in  1  one-cycle pulse: line data has been written
- tag_raddr  out  INDEX_WIDTH  tag-store read index
- tag_re  out  1  tag-store read enable
- tag_waddr  out  INDEX_WIDTH  tag-store write index
- tag_we  out  1  LRU-bit-only write enable
- tag_lru_addr  out  INDEX_WIDTH  index for the LRU-only write
- tag_refill  out  1  full-word write (both way fields plus LRU)
- tag_select  out  1  steers the tag-store address to tag_waddr; always 0 in this block
- tag_init_n  out  1  0 = tag store in clear sweep
- tag_din  out  WORD_WIDTH  write data
- tag_dout  in  WORD_WIDTH  read data, valid 1 cycle after the address

Behaviour:
- States: INIT, IDLE, LOOKUP, MISS, REFILL_WAIT, REFILL_WR.
- On rst assertion, asynchronously:
  - state = INIT, init counter = 0.
  - All outputs 0 except tag_init_n = 0.
  - Any outstanding request is dropped; no response is issued for it.
- INIT: tag_init_n = 0 for exactly 1<<INDEX_WIDTH cycles after rst deasserts (128 by default). Then tag_init_n = 1 and state -> IDLE. req_ready = 0 throughout.
- IDLE:
  - req_ready = 1.
  - tag_raddr = req_index and tag_re = req_valid, both combinational.
  - On req_valid & req_ready, latch index and tag, then -> LOOKUP.
- LOOKUP (one cycle after accept): tag_dout is valid and is latched as old_word. Per way w: hit_w = valid_w & (tag_w == req_tag).
  - If hit_w and hit_(1-w) are both set, way 0 wins.
  - Hit, in the same cycle:
    - resp_valid = 1, resp_hit = 1, resp_way = hit way.
    - tag_we = 1, tag_lru_addr = index, tag_din[44] = ~hit way.
    - -> IDLE.
    - Hit latency is 1 cycle after accept; sustained throughput is one request per 2 cycles.
  - Miss: victim = lowest-numbered invalid way if any, else lru bit (old_word[44]) -> MISS.
- MISS:
  - miss_valid = 1 with miss_index, miss_tag, miss_way held stable until miss_ready.
  - On miss_valid & miss_ready -> REFILL_WAIT.
- REFILL_WAIT: all strobes low. A refill_done pulse -> REFILL_WR. refill_done in any other state is ignored.
- REFILL_WR (one cycle), word write:
  - tag_refill = 1, tag_waddr = index.
  - tag_din: victim field = {1, req_tag}; non-victim field = old_word's field unchanged; bit 44 = ~victim; bits 43 and 21 = 0.
  - Same cycle: resp_valid = 1, resp_hit = 0, resp_way = victim. Then -> IDLE.
- The refill word write and the LRU-only write never occur in the same cycle.
- tag_din is 0 whenever neither write is active.
- The next lookup to the same set is accepted at the earliest one cycle after a write cycle, so the tag store sees no read-after-write hazard and no bypass is required.

Test Plan:
- Init sweep: release rst -> tag_init_n low exactly 128 cycles and req_ready = 0 throughout; then req_ready = 1.
- Cold miss: index 5, tag 0x12345 with both ways invalid -> miss_way = 0. Pulse refill_done -> tag_refill with tag_din[20:0] = 0x112345, tag_din[44] = 1, resp_hit = 0, resp_way = 0.
- Hit plus LRU update: after the cold miss, request index 5, tag 0x12345 -> resp_hit = 1 and resp_way = 0 one cycle after accept; tag_we = 1 with tag_din[44] = 1.
- Second fill then eviction: miss tag 0xABCDE -> way 1 filled and LRU = 0. Miss tag 0x00001 -> victim way 0, and way 1's field in tag_din equals {1, 0xABCDE}.
- Backpressure: hold miss_ready = 0 for 10 cycles -> miss_valid and the miss fields stay stable and req_ready = 0. Spurious refill_done while in MISS -> ignored.
- Reset mid-refill: assert rst in REFILL_WAIT -> outputs clear immediately with no resp_valid. After release the 128-cycle init sweep repeats, then the same request misses again.
